w_grf: RTL and testbench
========================

W_GRF -- requirements
Module: w_grf

Interface
REQ-001 The block SHALL expose clk input 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose reset input 1: synchronous, active-low reset (reset==0 at a rising clk edge resets).
REQ-003 The block SHALL expose W_WriteRegAddr input 5: destination register from the M->W pipeline register.
REQ-004 The block SHALL expose W_ALU_out, W_DM_out, W_PC and W_MDU_out, each input 32: the writeback candidate values.
REQ-005 The block SHALL expose W_CU_EN_RegWrite input 1: the writeback enable.
REQ-006 The block SHALL expose W_CU_GRFWriteData_Sel input 2: the write-data select.
REQ-007 The block SHALL expose W_T_new input 2: the remaining result latency, which must be 0 at W.
REQ-008 The block SHALL expose D_rs_addr and D_rt_addr, each input 5: the D-stage read addresses.
REQ-009 The block SHALL expose D_rs_data and D_rt_data, each output 32: the combinational read data.
REQ-010 The block SHALL expose W_WriteData output 32: the selected writeback value, which the hazard unit uses for W->D/E/M forwarding.
REQ-011 The block SHALL expose retire_valid output 1, retire_pc output 32, retire_addr output 5 and retire_data output 32: the registered retire trace.
REQ-012 The block SHALL expose retire_count output 32: the count of committed register writes.
REQ-013 The block SHALL expose tnew_err output 1: a sticky protocol-violation flag.

Function
REQ-014 W_WriteData SHALL be selected by W_CU_GRFWriteData_Sel: 00 gives W_ALU_out, 01 gives W_DM_out, 10 gives W_PC+8 (mod 2^32), 11 gives W_MDU_out.
REQ-015 A write is committed when W_CU_EN_RegWrite==1 and W_WriteRegAddr!=0: on that edge the GRF entry takes W_WriteData.
REQ-016 Register $0 SHALL read as 0 always; writes to it are discarded and are not counted.
REQ-017 D_rs_data and D_rt_data SHALL be combinational reads of the GRF, subject to REQ-027.
REQ-018 The edge after a committed write SHALL produce retire_valid=1, retire_pc=W_PC, retire_addr=W_WriteRegAddr and retire_data=W_WriteData, all with one-cycle latency.
REQ-019 On any other edge retire_valid SHALL be 0 and the other retire outputs SHALL hold their last values.
REQ-020 retire_count SHALL increment by 1 per committed write and wrap from 0xFFFF_FFFF to 0.
REQ-021 tnew_err SHALL set on the edge where W_CU_EN_RegWrite==1 and W_T_new!=0, and stay set until reset.
REQ-022 Reads and the write to the same address in the same cycle SHALL follow REQ-027; reads of other addresses are unaffected.

Reset
REQ-023 When reset==0 at an edge, all 31 GRF entries SHALL clear to 0x0000_0000.
REQ-024 When reset==0 at an edge, retire_valid SHALL clear to 0, retire_pc, retire_addr, retire_data and retire_count SHALL clear to 0, and tnew_err SHALL clear to 0.
REQ-025 Reset SHALL take priority over a simultaneous write, which is dropped and not counted.
REQ-026 Read ports SHALL return 0 during reset and the cycle after, because the array is cleared.

Configuration
REQ-027 The macro GRF_BYPASS_EN SHALL control internal write-through: when defined, a read whose address equals a committed write address (nonzero, enable=1, reset==1) returns W_WriteData in the same cycle; when undefined, the read returns the pre-write stored value and the hazard unit must forward.

Structure
REQ-028 The shared package mips_pkg SHALL hold the write-select constants WD_SEL_ALU=2'b00, WD_SEL_DM=2'b01, WD_SEL_PC8=2'b10 and WD_SEL_MDU=2'b11, plus the GRF width (32) and depth (32).
REQ-029 The storage array SHALL be a sub-module grf_bank with one write port and two asynchronous read ports; the selection, bypass, trace, counter and error logic SHALL live in w_grf.

Verification
REQ-030 Reset case: hold reset=0 for 2 cycles, then read $1..$31 -> all read 0, retire_count=0, tnew_err=0.
REQ-031 Select case: write $5 with Sel=10 and W_PC=0x0000_3000 -> next cycle $5=0x0000_3008, retire_valid=1, retire_pc=0x3000, retire_addr=5, retire_count=1.
REQ-032 $0 case: write $0 with 0xDEAD_BEEF -> $0 reads 0, retire_valid=0, retire_count unchanged.
REQ-033 Same-cycle case: write $8 with 0x1234_5678 while D_rs_addr=8 -> with GRF_BYPASS_EN the read gives 0x1234_5678 that cycle; without it the read gives the old value, then 0x1234_5678 next cycle.
REQ-034 Error and reset-priority case: write enabled with W_T_new=01 -> tnew_err=1 and it stays 1; a write with reset=0 on the same edge -> target stays 0 and the count is not incremented.
REQ-035 Wrap case: force retire_count to 0xFFFF_FFFF, then one committed write -> retire_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: writeback data selects and GRF geometry.
package mips_pkg;

  localparam int GRF_WIDTH = 32;
  localparam int GRF_DEPTH = 32;
  localparam int GRF_AW    = 5;

  localparam logic [1:0] WD_SEL_ALU = 2'b00;
  localparam logic [1:0] WD_SEL_DM  = 2'b01;
  localparam logic [1:0] WD_SEL_PC8 = 2'b10;
  localparam logic [1:0] WD_SEL_MDU = 2'b11;

endpackage

// File: rtl/grf_bank.sv
// General register file storage: one synchronous write port, two asynchronous
// read ports. Entry 0 is held at zero so $0 always reads 0.
module grf_bank
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [GRF_AW-1:0]     waddr,
  input  logic [GRF_WIDTH-1:0]  wdata,
  input  logic [GRF_AW-1:0]     raddr_a,
  input  logic [GRF_AW-1:0]     raddr_b,
  output logic [GRF_WIDTH-1:0]  rdata_a,
  output logic [GRF_WIDTH-1:0]  rdata_b
);

  logic [GRF_WIDTH-1:0] mem_q [GRF_DEPTH];
  logic [GRF_WIDTH-1:0] mem_d [GRF_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/w_grf.sv
// W-stage register file wrapper: writeback select, optional write-through
// (GRF_BYPASS_EN), retire trace, commit counter and sticky T_new error flag.
module w_grf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  W_WriteRegAddr,
  input  logic [31:0] W_ALU_out,
  input  logic [31:0] W_DM_out,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_MDU_out,
  input  logic        W_CU_EN_RegWrite,
  input  logic [1:0]  W_CU_GRFWriteData_Sel,
  input  logic [1:0]  W_T_new,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic [31:0] W_WriteData,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [4:0]  retire_addr,
  output logic [31:0] retire_data,
  output logic [31:0] retire_count,
  output logic        tnew_err
);

  logic        commit;
  logic [31:0] bank_rs, bank_rt;

  logic        retire_valid_q, retire_valid_d;
  logic [31:0] retire_pc_q, retire_pc_d;
  logic [4:0]  retire_addr_q, retire_addr_d;
  logic [31:0] retire_data_q, retire_data_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic        tnew_err_q, tnew_err_d;

  always_comb begin
    W_WriteData = W_ALU_out;
    case (W_CU_GRFWriteData_Sel)
      WD_SEL_ALU: W_WriteData = W_ALU_out;
      WD_SEL_DM:  W_WriteData = W_DM_out;
      WD_SEL_PC8: W_WriteData = W_PC + 32'd8;
      WD_SEL_MDU: W_WriteData = W_MDU_out;
      default:    W_WriteData = W_ALU_out;
    endcase
  end

  assign commit = W_CU_EN_RegWrite && (W_WriteRegAddr != 5'd0);

  grf_bank u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (commit),
    .waddr   (W_WriteRegAddr),
    .wdata   (W_WriteData),
    .raddr_a (D_rs_addr),
    .raddr_b (D_rt_addr),
    .rdata_a (bank_rs),
    .rdata_b (bank_rt)
  );

  // Reads are forced to 0 while reset is low since the array is being cleared.
  always_comb begin
    D_rs_data = bank_rs;
    D_rt_data = bank_rt;
`ifdef GRF_BYPASS_EN
    if (commit && (D_rs_addr == W_WriteRegAddr)) D_rs_data = W_WriteData;
    if (commit && (D_rt_addr == W_WriteRegAddr)) D_rt_data = W_WriteData;
`endif
    if (!reset) begin
      D_rs_data = '0;
      D_rt_data = '0;
    end
  end

  always_comb begin
    retire_valid_d = commit;
    retire_pc_d    = retire_pc_q;
    retire_addr_d  = retire_addr_q;
    retire_data_d  = retire_data_q;
    retire_count_d = retire_count_q;
    if (commit) begin
      retire_pc_d    = W_PC;
      retire_addr_d  = W_WriteRegAddr;
      retire_data_d  = W_WriteData;
      retire_count_d = retire_count_q + 32'd1;
    end
    tnew_err_d = tnew_err_q | (W_CU_EN_RegWrite && (W_T_new != 2'd0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_addr_q  <= '0;
      retire_data_q  <= '0;
      retire_count_q <= '0;
      tnew_err_q     <= 1'b0;
    end else begin
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_addr_q  <= retire_addr_d;
      retire_data_q  <= retire_data_d;
      retire_count_q <= retire_count_d;
      tnew_err_q     <= tnew_err_d;
    end
  end

  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign retire_addr  = retire_addr_q;
  assign retire_data  = retire_data_q;
  assign retire_count = retire_count_q;
  assign tnew_err     = tnew_err_q;

endmodule

// File: tb/tb_w_grf.sv
// Self-checking bench for w_grf: directed cases followed by random traffic,
// all checked against a register-array reference model.
module tb_w_grf;

  logic        clk;
  logic        reset;
  logic [4:0]  W_WriteRegAddr;
  logic [31:0] W_ALU_out, W_DM_out, W_PC, W_MDU_out;
  logic        W_CU_EN_RegWrite;
  logic [1:0]  W_CU_GRFWriteData_Sel;
  logic [1:0]  W_T_new;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_WriteData;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [4:0]  retire_addr;
  logic [31:0] retire_data;
  logic [31:0] retire_count;
  logic        tnew_err;

  w_grf dut (
    .clk                   (clk),
    .reset                 (reset),
    .W_WriteRegAddr        (W_WriteRegAddr),
    .W_ALU_out             (W_ALU_out),
    .W_DM_out              (W_DM_out),
    .W_PC                  (W_PC),
    .W_MDU_out             (W_MDU_out),
    .W_CU_EN_RegWrite      (W_CU_EN_RegWrite),
    .W_CU_GRFWriteData_Sel (W_CU_GRFWriteData_Sel),
    .W_T_new               (W_T_new),
    .D_rs_addr             (D_rs_addr),
    .D_rt_addr             (D_rt_addr),
    .D_rs_data             (D_rs_data),
    .D_rt_data             (D_rt_data),
    .W_WriteData           (W_WriteData),
    .retire_valid          (retire_valid),
    .retire_pc             (retire_pc),
    .retire_addr           (retire_addr),
    .retire_data           (retire_data),
    .retire_count          (retire_count),
    .tnew_err              (tnew_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_regs [32];
  logic        m_rv;
  logic [31:0] m_rpc, m_rdata, m_count;
  logic [4:0]  m_raddr;
  logic        m_err;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_value(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] dm, input logic [31:0] pc,
                                           input logic [31:0] mdu);
    if (sel == 2'd0) return alu;
    if (sel == 2'd1) return dm;
    if (sel == 2'd2) return pc + 32'd8;
    return mdu;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic do_write,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (!reset) return 32'd0;
    if (a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
    if (do_write && a == wa) return wd;
`endif
    return m_regs[a];
  endfunction

  // driver: called right after a falling edge; applies inputs, checks the
  // combinational outputs, then checks the registered outputs after the edge
  task automatic drive(input logic rst, input logic en, input logic [4:0] wa,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc, input logic [31:0] mdu, input logic [1:0] tnew,
                       input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] wd;
    logic        do_write;
    reset = rst; W_CU_EN_RegWrite = en; W_WriteRegAddr = wa;
    W_CU_GRFWriteData_Sel = sel; W_ALU_out = alu; W_DM_out = dm;
    W_PC = pc; W_MDU_out = mdu; W_T_new = tnew;
    D_rs_addr = rs; D_rt_addr = rt;
    #1;
    wd = sel_value(sel, alu, dm, pc, mdu);
    do_write = rst && en && (wa != 5'd0);
    check_eq("write_data", W_WriteData, wd);
    check_eq("rs_data", D_rs_data, model_read(rs, do_write, wa, wd));
    check_eq("rt_data", D_rt_data, model_read(rt, do_write, wa, wd));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_rv = 1'b0; m_rpc = 32'd0; m_raddr = 5'd0; m_rdata = 32'd0;
      m_count = 32'd0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      if (en && tnew != 2'd0) m_err = 1'b1;
      m_rv = do_write;
      if (do_write) begin
        m_regs[wa] = wd;
        m_rpc = pc; m_raddr = wa; m_rdata = wd;
        m_count = m_count + 32'd1;
        exp_q.push_back(wd);
      end
    end
    #1;
    check_eq("retire_valid", {31'd0, retire_valid}, {31'd0, m_rv});
    check_eq("retire_pc", retire_pc, m_rpc);
    check_eq("retire_addr", {27'd0, retire_addr}, {27'd0, m_raddr});
    check_eq("retire_data", retire_data, m_rdata);
    check_eq("retire_count", retire_count, m_count);
    check_eq("tnew_err", {31'd0, tnew_err}, {31'd0, m_err});
    if (retire_valid) begin
      if (exp_q.size() == 0) check_eq("retire_sb_empty", 32'd1, 32'd0);
      else check_eq("retire_sb", retire_data, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, rs, rt);
  endtask

  task automatic write_alu(input logic [4:0] wa, input logic [31:0] v, input logic [4:0] rs);
    drive(1'b1, 1'b1, wa, 2'd0, v, 32'd0, 32'h100, 32'd0, 2'd0, rs, 5'd0);
  endtask

  initial begin
    reset = 1'b0; W_CU_EN_RegWrite = 1'b0; W_WriteRegAddr = '0;
    W_CU_GRFWriteData_Sel = '0; W_ALU_out = '0; W_DM_out = '0; W_PC = '0;
    W_MDU_out = '0; W_T_new = '0; D_rs_addr = '0; D_rt_addr = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_rv = 0; m_rpc = 0; m_raddr = 0; m_rdata = 0; m_count = 0; m_err = 0;
    @(negedge clk);

    // reset held two cycles, then sweep all registers
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd1, 5'd2);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd3, 5'd4);
    for (int i = 1; i < 32; i++) idle_read(5'(i), 5'(32 - i));

    // each write-data select
    drive(1'b1, 1'b1, 5'd5, 2'b10, 32'h1, 32'h2, 32'h0000_3000, 32'h3, 2'd0, 5'd5, 5'd0);
    idle_read(5'd5, 5'd5);
    drive(1'b1, 1'b1, 5'd6, 2'b01, 32'h1, 32'hAAAA_5555, 32'h4, 32'h3, 2'd0, 5'd6, 5'd5);
    drive(1'b1, 1'b1, 5'd7, 2'b11, 32'h1, 32'h2, 32'h4, 32'hC0FF_EE00, 2'd0, 5'd7, 5'd6);
    drive(1'b1, 1'b1, 5'd31, 2'b10, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h3, 2'd0, 5'd31, 5'd7);
    idle_read(5'd31, 5'd7);

    // $0 write is discarded
    write_alu(5'd0, 32'hDEAD_BEEF, 5'd0);
    idle_read(5'd0, 5'd0);

    // same-cycle read of the write target
    write_alu(5'd8, 32'h1111_0000, 5'd0);
    write_alu(5'd8, 32'h1234_5678, 5'd8);
    idle_read(5'd8, 5'd8);

    // T_new violation is sticky; a write on a $0 target still flags it
    drive(1'b1, 1'b1, 5'd9, 2'd0, 32'h99, 32'd0, 32'h200, 32'd0, 2'b01, 5'd9, 5'd0);
    idle_read(5'd9, 5'd0);
    drive(1'b1, 1'b1, 5'd0, 2'd0, 32'h77, 32'd0, 32'h204, 32'd0, 2'b10, 5'd0, 5'd0);
    idle_read(5'd1, 5'd2);

    // reset wins over a simultaneous write
    drive(1'b0, 1'b1, 5'd10, 2'd0, 32'h5555_AAAA, 32'd0, 32'h300, 32'd0, 2'd0, 5'd10, 5'd9);
    idle_read(5'd10, 5'd9);

    // counter wrap
    dut.retire_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    check_eq("count_preset", retire_count, 32'hFFFF_FFFF);
    write_alu(5'd11, 32'h0BAD_F00D, 5'd11);
    idle_read(5'd11, 5'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom,
            (($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0),
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
